dcache_ctrl: RTL and testbench
==============================

# dcache_ctrl

Blocking, direct-mapped, write-back, write-allocate data cache between the CPU memory stage (load/store port, stall source) and the main-memory bus. Hits complete in one lookup cycle; misses stall the CPU, write back a dirty victim, refill the line in 128-bit beats, then replay the request. The instruction side is unaffected.

## Interface
- LINES, 64: number of lines (power of two)
- Line size: fixed at 64 B (16 words, 4 beats of 128 b); offset = addr[5:0], index = addr[5+log2(LINES):6], tag = remaining upper bits
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cpu_req_valid  in  1  load/store request present
- cpu_req_addr  in  32  byte address, word-aligned
- cpu_req_data  in  32  store data
- cpu_req_write  in  4  byte write mask; 4'b0000 = load
- cpu_req_ready  out  1  request accepted when valid&ready; stall = valid & !ready
- cpu_resp_valid  out  1  request completed (load data valid)
- cpu_resp_data  out  32  load word
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts request
- mem_req_rw  out  1  1 = write beat, 0 = line read
- mem_req_addr  out  28  128-bit beat address (byte addr[31:4])
- mem_req_data  out  128  write beat data
- mem_req_mask  out  16  write byte mask, always 16'hFFFF
- mem_resp_valid  in  1  read beat returned, in order, 4 per read request
- mem_resp_data  in  128  read beat

## Operation
- States: IDLE, LOOKUP, WRITEBACK, REFILL_REQ, REFILL_WAIT, REPLAY, RESPOND.
- IDLE/LOOKUP: accepted request registered; tag/data arrays read synchronously; compare in following cycle.
- Hit load: resp_valid, resp_data = addressed word; ready stays high (back-to-back loads at 1/cycle).
- Hit store: masked bytes written, dirty set; resp_valid; ready low in that commit cycle only.
- Miss, victim valid&dirty: WRITEBACK issues 4 write requests, beats 0..3 at {victim_tag,index,beat}; each advances on mem_req_ready. Then REFILL_REQ.
- Miss, victim clean/invalid: straight to REFILL_REQ.
- REFILL_REQ: one read at {tag,index,2'b00}, held until mem_req_ready.
- REFILL_WAIT: 2-bit beat counter; each mem_resp_valid writes beat into line; after beat 3: tag written, valid=1, dirty=0.
- REPLAY: re-read array; store merges mask, sets dirty. RESPOND: resp_valid, ready high.
- mem_req_* held stable while mem_req_valid & !mem_req_ready.
- mem_resp_valid outside REFILL_WAIT ignored.
- Reset: all valid and dirty bits cleared, state IDLE, counters 0; in-flight transaction abandoned, dirty data discarded.

## Timing
- Reset values: cpu_req_ready 0 during reset, 1 the cycle after; cpu_resp_valid 0; mem_req_valid 0; mem_req_rw 0; cpu_resp_data 0.
- Hit latency: accepted cycle N -> resp_valid cycle N+1.
- Miss: resp_valid exactly 2 cycles after final refill beat (REPLAY, RESPOND); ready low from N+1 (combinational from compare) until RESPOND.
- Writeback with mem_req_ready tied high: 4 consecutive cycles.
- Same-index back-to-back load after store: store commit cycle blocks acceptance, so no forwarding path.
- Tag equal but valid=0 counts as miss.

## Structure
- Shared package dcache_pkg: state enum, LINE_BYTES=64, BEAT_BITS=128, BEATS=4, address field widths/slicing functions.
- One sub-module dcache_array: synchronous-read tag+data storage with per-byte write enable, swappable for SRAM macros; valid/dirty bits kept as flops in dcache_ctrl for single-cycle reset clear.

## Test plan
- Cold load 0x0000_1004, memory returns beats with word1 = 0xDEADBEEF -> one read req at beat addr 0x0000100, no writes, resp_data 0xDEADBEEF 2 cycles after beat 3.
- Reload 0x0000_1004 then 0x0000_1008 back-to-back -> resp_valid on consecutive cycles, no mem_req_valid.
- Store 0x0000_1004 mask 4'b0011 data 0x1234_5678 on hit, then load -> 0xDEAD5678; ready low exactly one cycle after store.
- Load 0x0000_2004 (same index, LINES=64) after dirty line -> 4 write beats at 0x0000100..0x0000103 carrying updated line, then read req 0x0000200.
- mem_req_ready held low 5 cycles during writeback -> mem_req_addr/data/rw stable, beat not skipped or repeated.
- Reset asserted in REFILL_WAIT after beat 1 -> IDLE, resp_valid never asserted, later mem_resp_valid ignored, load 0x0000_1004 misses again.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types, constants and address-slicing helpers for the direct-mapped data cache.
package dcache_pkg;

  localparam int unsigned LINE_BYTES  = 64;
  localparam int unsigned BEAT_BITS   = 128;
  localparam int unsigned BEATS       = 4;
  localparam int unsigned LINE_BITS   = LINE_BYTES * 8;
  localparam int unsigned LINE_ADDR_W = 26;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE        = 3'd0;
  localparam state_t S_LOOKUP      = 3'd1;
  localparam state_t S_WRITEBACK   = 3'd2;
  localparam state_t S_REFILL_REQ  = 3'd3;
  localparam state_t S_REFILL_WAIT = 3'd4;
  localparam state_t S_REPLAY      = 3'd5;
  localparam state_t S_RESPOND     = 3'd6;

  // Line address = {tag, index}; the split depends on the number of lines.
  function automatic logic [LINE_ADDR_W-1:0] line_addr(input logic [31:0] addr);
    return addr[31:6];
  endfunction

  function automatic logic [3:0] word_sel(input logic [31:0] addr);
    return addr[5:2];
  endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// CPU load/store port and main-memory bus of the data cache.
interface dcache_ctrl_if;

  logic         cpu_req_valid;
  logic [31:0]  cpu_req_addr;
  logic [31:0]  cpu_req_data;
  logic [3:0]   cpu_req_write;
  logic         cpu_req_ready;
  logic         cpu_resp_valid;
  logic [31:0]  cpu_resp_data;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic         mem_req_rw;
  logic [27:0]  mem_req_addr;
  logic [127:0] mem_req_data;
  logic [15:0]  mem_req_mask;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_data;

  // slave = cache controller, master = CPU and memory side
  modport slave (
    input  cpu_req_valid, cpu_req_addr, cpu_req_data, cpu_req_write,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output cpu_req_ready, cpu_resp_valid, cpu_resp_data,
    output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_mask
  );

  modport master (
    output cpu_req_valid, cpu_req_addr, cpu_req_data, cpu_req_write,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  cpu_req_ready, cpu_resp_valid, cpu_resp_data,
    input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_mask
  );

endinterface

// File: rtl/dcache_array.sv
// Synchronous-read tag and data storage with per-byte write enables (SRAM-macro shaped).
module dcache_array
  import dcache_pkg::*;
#(
  parameter int unsigned LINES = 64,
  parameter int unsigned IDX_W = 6,
  parameter int unsigned TAG_W = 20
) (
  input  logic                  clk,
  input  logic [IDX_W-1:0]      i_raddr,
  output logic [TAG_W-1:0]      o_rtag,
  output logic [LINE_BITS-1:0]  o_rdata,
  input  logic [IDX_W-1:0]      i_waddr,
  input  logic [LINE_BYTES-1:0] i_byte_we,
  input  logic [LINE_BITS-1:0]  i_wdata,
  input  logic                  i_tag_we,
  input  logic [TAG_W-1:0]      i_wtag
);

  logic [LINE_BITS-1:0] r_data [LINES];
  logic [TAG_W-1:0]     r_tag  [LINES];
  logic [LINE_BITS-1:0] r_rdata;
  logic [TAG_W-1:0]     r_rtag;

  // Read returns the pre-write contents when read and write hit the same line.
  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < LINE_BYTES; b++) begin
      if (i_byte_we[b]) r_data[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
    end
    if (i_tag_we) r_tag[i_waddr] <= i_wtag;
    r_rdata <= r_data[i_raddr];
    r_rtag  <= r_tag[i_raddr];
  end

  assign o_rdata = r_rdata;
  assign o_rtag  = r_rtag;

endmodule

// File: rtl/dcache_ctrl.sv
// Blocking direct-mapped write-back/write-allocate data cache controller.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned LINES = 64
) (
  input logic       clk,
  input logic       reset,
  dcache_ctrl_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = LINE_ADDR_W - IDX_W;

  state_t           r_state, w_state_d;
  logic [31:0]      r_addr, r_wdata;
  logic [3:0]       r_mask;
  logic [1:0]       r_beat;
  logic [LINES-1:0] r_valid, r_dirty;

  logic [LINE_ADDR_W-1:0] w_line;
  logic [IDX_W-1:0]       w_idx, w_cpu_idx, w_raddr;
  logic [TAG_W-1:0]       w_tag, w_rtag;
  logic [3:0]             w_word;
  logic [LINE_BITS-1:0]   w_rdata, w_wdata;
  logic [LINE_BYTES-1:0]  w_byte_we, w_store_be, w_fill_be;
  logic w_hit, w_store, w_accept, w_ready, w_resp_valid, w_mreq_valid, w_mreq_rw;
  logic w_fill, w_tag_we, w_set_dirty, w_beat_inc;
  logic [27:0]            w_mreq_addr;

  assign w_line     = line_addr(r_addr);
  assign w_idx      = IDX_W'(w_line);
  assign w_tag      = TAG_W'(w_line >> IDX_W);
  assign w_word     = word_sel(r_addr);
  assign w_cpu_idx  = IDX_W'(line_addr(bus.cpu_req_addr));
  assign w_store    = |r_mask;
  assign w_hit      = r_valid[w_idx] && (w_rtag == w_tag);
  assign w_accept   = bus.cpu_req_valid & w_ready;
  // Only a newly accepted request moves the read port; otherwise it tracks the current line.
  assign w_raddr    = w_accept ? w_cpu_idx : w_idx;
  assign w_store_be = LINE_BYTES'(r_mask) << {w_word, 2'b00};
  assign w_fill_be  = LINE_BYTES'(16'hFFFF) << {r_beat, 4'b0000};
  assign w_wdata    = w_fill ? {BEATS{bus.mem_resp_data}} : {16{r_wdata}};

  always_comb begin
    w_state_d    = r_state;
    w_ready      = 1'b0;
    w_resp_valid = 1'b0;
    w_mreq_valid = 1'b0;
    w_mreq_rw    = 1'b0;
    w_mreq_addr  = {w_tag, w_idx, 2'b00};
    w_byte_we    = '0;
    w_fill       = 1'b0;
    w_tag_we     = 1'b0;
    w_set_dirty  = 1'b0;
    w_beat_inc   = 1'b0;
    case (r_state)
      S_IDLE: w_ready = 1'b1;
      S_LOOKUP: begin
        if (w_hit) begin
          w_resp_valid = 1'b1;
          w_state_d    = S_IDLE;
          if (w_store) begin
            w_byte_we   = w_store_be;
            w_set_dirty = 1'b1;
          end else begin
            w_ready = 1'b1;
          end
        end else if (r_valid[w_idx] && r_dirty[w_idx]) begin
          w_state_d = S_WRITEBACK;
        end else begin
          w_state_d = S_REFILL_REQ;
        end
      end
      S_WRITEBACK: begin
        w_mreq_valid = 1'b1;
        w_mreq_rw    = 1'b1;
        w_mreq_addr  = {w_rtag, w_idx, r_beat};
        if (bus.mem_req_ready) begin
          w_beat_inc = 1'b1;
          if (r_beat == 2'd3) w_state_d = S_REFILL_REQ;
        end
      end
      S_REFILL_REQ: begin
        w_mreq_valid = 1'b1;
        if (bus.mem_req_ready) w_state_d = S_REFILL_WAIT;
      end
      S_REFILL_WAIT: begin
        if (bus.mem_resp_valid) begin
          w_fill     = 1'b1;
          w_byte_we  = w_fill_be;
          w_beat_inc = 1'b1;
          if (r_beat == 2'd3) begin
            w_tag_we  = 1'b1;
            w_state_d = S_REPLAY;
          end
        end
      end
      S_REPLAY: begin
        if (w_store) begin
          w_byte_we   = w_store_be;
          w_set_dirty = 1'b1;
        end
        w_state_d = S_RESPOND;
      end
      S_RESPOND: begin
        w_resp_valid = 1'b1;
        w_ready      = 1'b1;
        w_state_d    = S_IDLE;
      end
      default: w_state_d = S_IDLE;
    endcase
    if (w_ready && bus.cpu_req_valid) w_state_d = S_LOOKUP;
    if (reset) begin
      w_ready      = 1'b0;
      w_resp_valid = 1'b0;
      w_mreq_valid = 1'b0;
      w_mreq_rw    = 1'b0;
      w_byte_we    = '0;
      w_tag_we     = 1'b0;
      w_set_dirty  = 1'b0;
      w_beat_inc   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_beat  <= 2'd0;
      r_valid <= '0;
      r_dirty <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_mask  <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_beat_inc) r_beat <= r_beat + 2'd1;
      if (w_accept) begin
        r_addr  <= bus.cpu_req_addr;
        r_wdata <= bus.cpu_req_data;
        r_mask  <= bus.cpu_req_write;
      end
      if (w_tag_we) begin
        r_valid[w_idx] <= 1'b1;
        r_dirty[w_idx] <= 1'b0;
      end
      if (w_set_dirty) r_dirty[w_idx] <= 1'b1;
    end
  end

  dcache_array #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clk       (clk),
    .i_raddr   (w_raddr),
    .o_rtag    (w_rtag),
    .o_rdata   (w_rdata),
    .i_waddr   (w_idx),
    .i_byte_we (w_byte_we),
    .i_wdata   (w_wdata),
    .i_tag_we  (w_tag_we),
    .i_wtag    (w_tag)
  );

  assign bus.cpu_req_ready  = w_ready;
  assign bus.cpu_resp_valid = w_resp_valid;
  assign bus.cpu_resp_data  = w_resp_valid ? w_rdata[{w_word, 5'd0} +: 32] : 32'd0;
  assign bus.mem_req_valid  = w_mreq_valid;
  assign bus.mem_req_rw     = w_mreq_rw;
  assign bus.mem_req_addr   = w_mreq_addr;
  assign bus.mem_req_data   = w_rdata[{r_beat, 7'd0} +: BEAT_BITS];
  assign bus.mem_req_mask   = 16'hFFFF;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: flat-memory reference model plus hand-computed expectations.
module tb_dcache_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  dcache_ctrl_if bus();

  dcache_ctrl #(.LINES(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Architectural model: backing memory words plus CPU-visible overrides from stores.
  logic [31:0] mem_w [int unsigned];
  logic [31:0] gold  [int unsigned];

  typedef struct {
    bit          is_load;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  logic [27:0]  wr_addr_q[$];
  logic [127:0] wr_data_q[$];
  int           wr_cyc_q[$];
  logic [27:0]  rd_addr_q[$];
  int           rd_cyc_q[$];
  int           resp_cyc_q[$];
  logic [31:0]  resp_data_q[$];
  logic [127:0] beat_q[$];
  int stall_seen = 0, memv_cycles = 0, resp_count = 0, beats_driven = 0;
  int acc_cyc_last = 0, last_beat_cyc = 0, stall_left = 0;
  logic [31:0] last_resp_data;

  function automatic logic [31:0] dflt(input int unsigned wa);
    return {wa[15:0], ~wa[15:0]} ^ 32'h3C3C_0000;
  endfunction

  function automatic logic [31:0] mem_word(input int unsigned wa);
    return mem_w.exists(wa) ? mem_w[wa] : dflt(wa);
  endfunction

  function automatic logic [31:0] gold_word(input int unsigned wa);
    return gold.exists(wa) ? gold[wa] : mem_word(wa);
  endfunction

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    rd_addr_q.delete(); rd_cyc_q.delete();
    resp_cyc_q.delete(); resp_data_q.delete();
    stall_seen = 0;
  endtask

  // Compare process: reset values, responses, write-back contents and request stability.
  initial begin
    logic         p_valid, p_ready, p_rw;
    logic [27:0]  p_addr;
    logic [127:0] p_data;
    p_valid = 1'b0; p_ready = 1'b1; p_rw = 1'b0; p_addr = '0; p_data = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        check("rst_outputs", {bus.cpu_req_ready, bus.cpu_resp_valid, bus.mem_req_valid,
                              bus.mem_req_rw, bus.cpu_resp_data}, '0);
        p_valid = 1'b0;
      end else begin
        if (bus.cpu_resp_valid) begin
          resp_count++;
          resp_cyc_q.push_back(cyc);
          resp_data_q.push_back(bus.cpu_resp_data);
          last_resp_data = bus.cpu_resp_data;
          if (exp_q.size() == 0) begin
            check("unexpected_resp", bus.cpu_resp_valid, 0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.is_load) check("load_data", bus.cpu_resp_data, e.data);
          end
        end
        if (bus.mem_req_valid) memv_cycles++;
        if (p_valid && !p_ready) begin
          stall_seen++;
          check("req_hold", {bus.mem_req_valid, bus.mem_req_rw, bus.mem_req_addr, bus.mem_req_data},
                {1'b1, p_rw, p_addr, p_data});
        end
        if (bus.mem_req_valid && bus.mem_req_ready) begin
          int unsigned wa;
          wa = {bus.mem_req_addr, 2'b00};
          if (bus.mem_req_rw) begin
            check("wb_mask", bus.mem_req_mask, 16'hFFFF);
            for (int i = 0; i < 4; i++) begin
              check("wb_word", bus.mem_req_data[i*32 +: 32], gold_word(wa + i));
              mem_w[wa + i] = bus.mem_req_data[i*32 +: 32];
            end
            wr_addr_q.push_back(bus.mem_req_addr);
            wr_data_q.push_back(bus.mem_req_data);
            wr_cyc_q.push_back(cyc);
          end else begin
            rd_addr_q.push_back(bus.mem_req_addr);
            rd_cyc_q.push_back(cyc);
            for (int b = 0; b < 4; b++) begin
              logic [127:0] bt;
              for (int i = 0; i < 4; i++) bt[i*32 +: 32] = mem_word(wa + b*4 + i);
              beat_q.push_back(bt);
            end
          end
        end
        if (bus.cpu_req_valid && bus.cpu_req_ready) begin
          exp_t e;
          int unsigned wa;
          logic [31:0] w;
          wa = bus.cpu_req_addr >> 2;
          w  = gold_word(wa);
          e.is_load = (bus.cpu_req_write == 4'b0000);
          e.data    = w;
          for (int b = 0; b < 4; b++)
            if (bus.cpu_req_write[b]) w[b*8 +: 8] = bus.cpu_req_data[b*8 +: 8];
          if (!e.is_load) gold[wa] = w;
          exp_q.push_back(e);
        end
        p_valid = bus.mem_req_valid;
      end
      p_ready = bus.mem_req_ready;
      p_rw    = bus.mem_req_rw;
      p_addr  = bus.mem_req_addr;
      p_data  = bus.mem_req_data;
    end
  end

  // Memory side: in-order read beats back-to-back; optional stall on write beat 1.
  initial begin
    bus.mem_req_ready  = 1'b1;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (beat_q.size() > 0) begin
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = beat_q.pop_front();
        beats_driven++;
        last_beat_cyc = cyc;
      end else begin
        bus.mem_resp_valid = 1'b0;
      end
      if (stall_left > 0 && bus.mem_req_valid && bus.mem_req_rw && bus.mem_req_addr[1:0] == 2'd1) begin
        bus.mem_req_ready = 1'b0;
        stall_left--;
      end else begin
        bus.mem_req_ready = 1'b1;
      end
    end
  end

  task automatic cpu_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    bit ok;
    ok = 1'b0;
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_addr  = a;
    bus.cpu_req_data  = d;
    bus.cpu_req_write = m;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (bus.cpu_req_ready) begin
        ok = 1'b1;
        acc_cyc_last = cyc;
      end
    end
    if (!ok) check("accept_timeout", bus.cpu_req_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_idle();
    bus.cpu_req_valid = 1'b0;
    bus.cpu_req_write = 4'b0000;
  endtask

  task automatic wait_resp(input int maxc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(negedge clk);
      if (bus.cpu_resp_valid) ok = 1'b1;
    end
    if (!ok) check("resp_timeout", bus.cpu_resp_valid, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int a0, a1, m0, b0, r0;
    bit hit;
    bus.cpu_req_valid = 1'b0;
    bus.cpu_req_addr  = '0;
    bus.cpu_req_data  = '0;
    bus.cpu_req_write = 4'b0000;
    mem_w[32'h1004 >> 2] = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", bus.cpu_req_ready, 1);
    @(posedge clk); #1;

    // Cold miss, clean victim
    clear_logs();
    cpu_req(32'h0000_1004, 32'h0, 4'b0000); cpu_idle(); wait_resp(100);
    check("t1_rd_cnt", rd_addr_q.size(), 1);
    check("t1_rd_addr", rd_addr_q[0], 28'h0000100);
    check("t1_wr_cnt", wr_addr_q.size(), 0);
    check("t1_data", last_resp_data, 32'hDEADBEEF);
    check("t1_latency", last_resp_cyc_diff(), 2);

    // Back-to-back hits
    clear_logs(); m0 = memv_cycles;
    cpu_req(32'h0000_1004, 32'h0, 4'b0000);
    cpu_req(32'h0000_1008, 32'h0, 4'b0000);
    cpu_idle();
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    check("t2_resp_cnt", resp_cyc_q.size(), 2);
    check("t2_consecutive", resp_cyc_q[1] - resp_cyc_q[0], 1);
    check("t2_data0", resp_data_q[0], 32'hDEADBEEF);
    check("t2_data1", resp_data_q[1], {16'h0402, 16'hFBFD} ^ 32'h3C3C_0000);
    check("t2_no_mem", memv_cycles - m0, 0);

    // Hit store then load
    clear_logs();
    cpu_req(32'h0000_1004, 32'h1234_5678, 4'b0011); a0 = acc_cyc_last;
    cpu_req(32'h0000_1004, 32'h0, 4'b0000);         a1 = acc_cyc_last;
    cpu_idle(); wait_resp(20);
    check("t3_ready_gap", a1 - a0, 2);
    check("t3_store_resp", resp_cyc_q[0], a0 + 1);
    check("t3_hit_latency", resp_cyc_q[1], a1 + 1);
    check("t3_data", last_resp_data, 32'hDEAD5678);

    // Conflict miss with dirty victim
    clear_logs();
    cpu_req(32'h0000_2004, 32'h0, 4'b0000); cpu_idle(); wait_resp(100);
    check("t4_wr_cnt", wr_addr_q.size(), 4);
    for (int i = 0; i < 4; i++) check("t4_wr_addr", wr_addr_q[i], 28'h0000100 + 28'(i));
    check("t4_wr_word1", wr_data_q[0][63:32], 32'hDEAD5678);
    check("t4_wr_back2back", wr_cyc_q[3] - wr_cyc_q[0], 3);
    check("t4_rd_addr", rd_addr_q[0], 28'h0000200);
    check("t4_rd_after_wr", rd_cyc_q[0] > wr_cyc_q[3], 1);

    // Writeback stalled by mem_req_ready
    cpu_req(32'h0000_2004, 32'hCAFE_F00D, 4'b1111); cpu_idle(); wait_resp(20);
    clear_logs(); stall_left = 5;
    cpu_req(32'h0000_1004, 32'h0, 4'b0000); cpu_idle(); wait_resp(200);
    check("t5_wr_cnt", wr_addr_q.size(), 4);
    for (int i = 0; i < 4; i++) check("t5_wr_addr", wr_addr_q[i], 28'h0000200 + 28'(i));
    check("t5_stall_cycles", stall_seen, 5);
    check("t5_wr_word1", wr_data_q[0][63:32], 32'hCAFE_F00D);
    check("t5_rd_addr", rd_addr_q[0], 28'h0000100);
    check("t5_data", last_resp_data, 32'hDEAD5678);

    // Reset during refill
    clear_logs(); b0 = beats_driven; hit = 1'b0;
    cpu_req(32'h0000_3004, 32'h0, 4'b0000); cpu_idle();
    for (int i = 0; i < 100 && !hit; i++) begin
      @(posedge clk); #2;
      if (beats_driven - b0 >= 3) hit = 1'b1;
    end
    check("t6_beats_seen", beats_driven - b0 >= 3, 1);
    reset = 1'b1;
    exp_q.delete(); gold.delete(); r0 = resp_count;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("t6_ready_after_reset", bus.cpu_req_ready, 1);
    repeat (8) @(posedge clk); #1;
    check("t6_no_resp", resp_count - r0, 0);
    clear_logs();
    cpu_req(32'h0000_1004, 32'h0, 4'b0000); cpu_idle(); wait_resp(100);
    check("t6_remiss_rd_cnt", rd_addr_q.size(), 1);
    check("t6_remiss_addr", rd_addr_q[0], 28'h0000100);
    check("t6_remiss_wr_cnt", wr_addr_q.size(), 0);
    check("t6_data", last_resp_data, 32'hDEAD5678);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  function automatic int last_resp_cyc_diff();
    return resp_cyc_q[resp_cyc_q.size() - 1] - last_beat_cyc;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule
